// File: rtl/gl_reg_sta_if.sv
// gl_reg_sta_if: bus bundle for the data-register and sticky-status slices.
interface gl_reg_sta_if #(
    parameter int REG_W = 8,
    parameter int STA_W = 8
);
    logic             reg_we;
    logic [REG_W-1:0] reg_wdat;
    logic [REG_W-1:0] reg_q;
    logic             sta_rst0;
    logic [STA_W-1:0] sta_set;
    logic [STA_W-1:0] sta_clr;
    logic [STA_W-1:0] sta_q;
    logic [STA_W-1:0] sta_irq;

    modport master (
        output reg_we, reg_wdat, sta_rst0, sta_set, sta_clr,
        input  reg_q, sta_q, sta_irq
    );

    modport slave (
        input  reg_we, reg_wdat, sta_rst0, sta_set, sta_clr,
        output reg_q, sta_q, sta_irq
    );
endinterface

// File: rtl/gl_reg_sta.sv
// gl_reg_sta: write-enabled data register plus set-beats-clear sticky status with irq.
// GLSTA_IRQ_LEVEL_EN: sta_irq mirrors sta_q (level) instead of a one-cycle set pulse.
module gl_reg_sta #(
    parameter int               REG_W    = 8,
    parameter int               STA_W    = 8,
    parameter logic [REG_W-1:0] REG_RSTV = '0
) (
    input logic          clk,
    input logic          srstz,
    gl_reg_sta_if.slave  bus
);
    logic [REG_W-1:0] reg_r;
    logic [STA_W-1:0] sta_r;

    always_ff @(posedge clk) begin
        if (!srstz) begin
            reg_r <= REG_RSTV;
            sta_r <= '0;
        end else begin
            if (bus.reg_we) reg_r <= bus.reg_wdat;
            // set is OR'd after the clear mask so a colliding clear is lost
            sta_r <= bus.sta_rst0 ? '0 : (sta_r & ~bus.sta_clr) | bus.sta_set;
        end
    end

`ifdef GLSTA_IRQ_LEVEL_EN
    assign bus.sta_irq = sta_r;
`else
    logic [STA_W-1:0] irq_r;

    always_ff @(posedge clk) begin
        if (!srstz || bus.sta_rst0) irq_r <= '0;
        else irq_r <= bus.sta_set;
    end

    assign bus.sta_irq = irq_r;
`endif

    assign bus.reg_q = reg_r;
    assign bus.sta_q = sta_r;
endmodule

// File: tb/tb_gl_reg_sta.sv
// tb_gl_reg_sta: directed checks of gl_reg_sta in either irq build.
module tb_gl_reg_sta;
    logic clk = 1'b0;
    logic srstz;
    int   total = 0;
    int   bad = 0;

    gl_reg_sta_if #(.REG_W(8), .STA_W(8)) bus ();

    gl_reg_sta #(.REG_W(8), .STA_W(8), .REG_RSTV(8'h00)) dut (
        .clk   (clk),
        .srstz (srstz),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] r, input logic [7:0] q,
                           input logic [7:0] irq_pulse, input logic [7:0] irq_level);
        chk({tag, "_reg"}, bus.reg_q, r);
        chk({tag, "_sta"}, bus.sta_q, q);
`ifdef GLSTA_IRQ_LEVEL_EN
        chk({tag, "_irq"}, bus.sta_irq, irq_level);
`else
        chk({tag, "_irq"}, bus.sta_irq, irq_pulse);
`endif
    endtask

    initial begin
        srstz = 1'b0;
        bus.reg_we = 1'b0;
        bus.reg_wdat = 8'h00;
        bus.sta_rst0 = 1'b0;
        bus.sta_set = 8'h00;
        bus.sta_clr = 8'h00;
        #2;
        step();
        chk_all("reset", 8'h00, 8'h00, 8'h00, 8'h00);

        srstz = 1'b1;
        bus.reg_we = 1'b1;
        bus.reg_wdat = 8'hA5;
        step();
        chk("write_a5", bus.reg_q, 8'hA5);
        bus.reg_we = 1'b0;
        bus.reg_wdat = 8'h3C;
        step();
        chk("hold_a5", bus.reg_q, 8'hA5);

        bus.sta_set = 8'h04;
        step();
        chk_all("set04", 8'hA5, 8'h04, 8'h04, 8'h04);
        bus.sta_set = 8'h00;
        step();
        chk_all("set04_after", 8'hA5, 8'h04, 8'h00, 8'h04);
        bus.sta_clr = 8'hFF;
        step();
        chk_all("clr_ff", 8'hA5, 8'h00, 8'h00, 8'h00);

        bus.sta_set = 8'h01;
        bus.sta_clr = 8'h01;
        step();
        chk_all("collide", 8'hA5, 8'h01, 8'h01, 8'h01);
        bus.sta_clr = 8'h00;
        step();
        chk_all("reset_again", 8'hA5, 8'h01, 8'h01, 8'h01);
        bus.sta_set = 8'h00;
        step();
        chk_all("irq_drop", 8'hA5, 8'h01, 8'h00, 8'h01);
        bus.sta_clr = 8'h01;
        step();
        chk_all("clr01", 8'hA5, 8'h00, 8'h00, 8'h00);

        bus.sta_clr = 8'h00;
        bus.sta_set = 8'h81;
        step();
        chk_all("set81", 8'hA5, 8'h81, 8'h81, 8'h81);
        bus.sta_set = 8'h00;
        bus.sta_clr = 8'h80;
        step();
        chk_all("clr80", 8'hA5, 8'h01, 8'h00, 8'h01);
        bus.sta_clr = 8'h00;
        bus.sta_set = 8'h02;
        bus.sta_rst0 = 1'b1;
        step();
        chk_all("rst0", 8'hA5, 8'h00, 8'h00, 8'h00);
        bus.sta_rst0 = 1'b0;

        bus.sta_set = 8'hFF;
        bus.reg_we = 1'b1;
        bus.reg_wdat = 8'h55;
        step();
        chk_all("fill", 8'h55, 8'hFF, 8'hFF, 8'hFF);
        bus.sta_set = 8'h00;
        bus.reg_we = 1'b0;
        step();
        chk_all("fill_hold", 8'h55, 8'hFF, 8'h00, 8'hFF);

        srstz = 1'b0;
        bus.reg_we = 1'b1;
        bus.reg_wdat = 8'h11;
        bus.sta_set = 8'hFF;
        #3;
        chk("no_async_reg", bus.reg_q, 8'h55);
        chk("no_async_sta", bus.sta_q, 8'hFF);
        step();
        chk_all("sync_rst", 8'h00, 8'h00, 8'h00, 8'h00);
        srstz = 1'b1;
        bus.reg_we = 1'b0;
        bus.sta_set = 8'h00;
        step();
        chk_all("post_rst", 8'h00, 8'h00, 8'h00, 8'h00);

        bus.sta_set = 8'h10;
        step();
        bus.sta_set = 8'h00;
        step();
        step();
        chk_all("lvl_hold", 8'h00, 8'h10, 8'h00, 8'h10);
        bus.sta_clr = 8'h10;
        step();
        chk_all("lvl_clr", 8'h00, 8'h00, 8'h00, 8'h00);
        bus.sta_clr = 8'h00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gl_reg_sta.md
Name: gl_reg_sta

Overview:
- Generic register primitive pair used throughout the SFR/DAC control logic, packaged as one block with two independent slices.
- Slice 1 is a parameterised write-enabled data register (DACV*, DACTL, DACEN, offsets, LSB fields).
- Slice 2 is a set/clear sticky status register with interrupt output (comparator-change status CMPSTA).
- All state is clocked on clk rising edge; no combinational path from any input to any output.

Parameters:
- REG_W, 8, width of the data-register slice (legal 1..32).
- STA_W, 8, width of the status slice (legal 1..32).
- REG_RSTV, 0 (REG_W bits), reset value loaded into reg_q.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- srstz  input  1  reset, synchronous, active-low.
- reg_we  input  1  data-register write enable.
- reg_wdat  input  REG_W  write data.
- reg_q  output  REG_W  registered data-register contents.
- sta_rst0  input  1  synchronous soft clear of the whole status slice, active-high.
- sta_set  input  STA_W  per-bit status set request.
- sta_clr  input  STA_W  per-bit status clear request (write-1-to-clear strobe).
- sta_q  output  STA_W  status bits.
- sta_irq  output  STA_W  per-bit interrupt request.

Behaviour:
- Reset: while srstz=0 at a clk edge, reg_q <= REG_RSTV, sta_q <= 0, sta_irq <= 0. srstz overrides every other input.
- Data register, per edge with srstz=1:
  - reg_we=1: reg_q <= reg_wdat, visible the cycle after the edge (1-cycle latency).
  - reg_we=0: hold.
  - No read-side effects. Width is exactly REG_W, no truncation or extension inside the block.
- Status register, per bit i, per edge with srstz=1, in priority order:
  1. sta_rst0=1: sta_q[i] <= 0, sta_irq[i] <= 0.
  2. sta_set[i]=1: sta_q[i] <= 1, regardless of sta_clr[i]. Set beats clear.
  3. sta_clr[i]=1: sta_q[i] <= 0.
  4. Otherwise: hold.
- A clear that collides with a set is lost. The bit stays 1, and the next set still raises the interrupt.
- Interrupt, default build, with srstz=1 and sta_rst0=0:
  - sta_irq[i] <= sta_set[i]. This is a one-cycle registered pulse the cycle after each set, independent of the prior sta_q[i].
  - Back-to-back sets on consecutive cycles hold sta_irq[i] high continuously. No extra pulses, no counting.
  - sta_clr has no effect on sta_irq.
- Bits are fully independent. Multiple bits may set or clear in the same cycle.
- Reset mid-operation: a pending set, clear or write in the same cycle as srstz=0 is discarded.
- Consumers form a level interrupt as OR of sta_irq, outside this block.

Optional Feature:
- Macro: GLSTA_IRQ_LEVEL_EN.
- Defined: sta_irq is driven directly as sta_q (level interrupt, no extra flops). sta_irq[i] stays high from the cycle after a set until the bit is cleared, soft-cleared or reset.
- Not defined: pulse behaviour as specified above.
- The data-register slice is unaffected either way.

Test Plan:
- Reset then write: srstz=0 one cycle, then srstz=1, reg_we=1, reg_wdat=0xA5 -> reg_q=0x00 during reset, 0xA5 one cycle after the write edge; reg_we=0 with wdat=0x3C -> reg_q holds 0xA5.
- Set/clear basic: sta_set=0x04 one cycle -> sta_q=0x04 and sta_irq=0x04 for exactly one cycle; then sta_clr=0xFF -> sta_q=0x00.
- Collision: sta_q=0x00, sta_set=0x01 and sta_clr=0x01 same cycle -> sta_q=0x01, sta_irq=0x01. Next cycle sta_set=0x01 again -> sta_irq=0x01 again.
- Independence and soft clear: sta_set=0x81, next cycle sta_clr=0x80 -> sta_q=0x01; sta_rst0=1 with sta_set=0x02 -> sta_q=0x00, sta_irq=0x00.
- Synchronous reset priority: sta_q=0xFF, reg_q=0x55, then srstz=0 with reg_we=1, reg_wdat=0x11, sta_set=0xFF -> all outputs 0 after the edge. No asynchronous clearing before the edge.
- Level-mode build (GLSTA_IRQ_LEVEL_EN defined): sta_set=0x10 one cycle -> sta_irq=0x10 held until sta_clr=0x10, then sta_irq=0x00.
